// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V main control FSM (fetch, decode, execute, memory, writeback).
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unlisted opcodes and raise the sticky 'illegal' flag.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e state_q, state_d;
  logic   pc_update_s, branch_s, ir_write_s, reg_write_s, mem_write_s;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      TRAP:     state_d = TRAP;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode; only the fetch strobes look at mem_ready.
  always_comb begin
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (state_q)
      FETCH: begin
        pc_update_s = mem_ready;
        ir_write_s  = mem_ready;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB:    reg_write_s = 1'b1;
      BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        branch_s = 1'b1;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        pc_update_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed during reset so an aborted instruction leaves no side effects.
  assign PCUpdate = pc_update_s & ~reset;
  assign Branch   = branch_s    & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign RegWrite = reg_write_s & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign state    = state_q;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | ((state_q == DECODE) && (state_d == TRAP));
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized self-checking bench for main_fsm against a per-instruction state/output model.
// Honours MAIN_FSM_ILLEGAL_TRAP_EN the same way the design does.
module tb_main_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [13:0] outs;

  int checks   = 0;
  int failures = 0;

  int         st_q[$];
  bit         mr_q[$];
  logic [6:0] cur_op;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [13:0] STROBE_MASK = 14'b11111_0_00_00_00_00;
  logic [6:0] legal_ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .Branch(Branch), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  // Control word the specification lists for each state number.
  function automatic logic [13:0] exp_out(int s, bit mr);
    logic pcu = 0, br = 0, irw = 0, rw = 0, mw = 0, adr = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, ao = 0;
    case (s)
      0:  begin pcu = mr; irw = mr; rs = 2'b10; sb = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; ao = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      8:  rw = 1;
      9:  begin sa = 2'b10; ao = 2'b01; br = 1; end
      10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    return {pcu, br, irw, rw, mw, adr, rs, sa, sb, ao};
  endfunction

  function automatic void push(int s, bit mr);
    st_q.push_back(s);
    mr_q.push_back(mr);
  endfunction

  // One instruction: fw fetch stalls, mw memory stalls, then the class-specific path.
  function automatic void model_instr(logic [6:0] o, int fw, int mw);
    for (int i = 0; i < fw; i++) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom_range(0, 1)));
    case (o)
      OP_LW: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push(5, 1'b0);
        push(5, 1'b1);
      end
      OP_R:   begin push(6, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
      OP_I:   begin push(7, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
      OP_BEQ: push(9, 1'($urandom_range(0, 1)));
      OP_JAL: begin push(10, 1'($urandom_range(0, 1))); push(8, 1'($urandom_range(0, 1))); end
      default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        push(11, 1'($urandom_range(0, 1)));
`endif
      end
    endcase
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; op = 7'($urandom);
      #1;
      checks++;
      if (state !== 4'd0 || illegal !== 1'b0 || outs !== (exp_out(0, 1'b1) & ~STROBE_MASK)) begin
        failures++;
        $display("[TB] FAIL reset: state=%0d outs=%b illegal=%b, expected state=0 outs=%b illegal=0",
                 state, outs, illegal, exp_out(0, 1'b1) & ~STROBE_MASK);
      end
    end
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_rtype();
    int s; bit m; logic [13:0] e;
    cur_op = OP_R;
    model_instr(OP_R, 0, 0);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
      #1;
      checks++;
      if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
        failures++;
        $display("[TB] FAIL rtype: state=%0d outs=%b illegal=%b, expected state=%0d outs=%b", state, outs, illegal, s, e);
      end
    end
  endtask

  task automatic test_lw_wait();
    int s; bit m; logic [13:0] e;
    cur_op = OP_LW;
    model_instr(OP_LW, 0, 2);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
      #1;
      checks++;
      if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
        failures++;
        $display("[TB] FAIL lw_wait: state=%0d outs=%b illegal=%b, expected state=%0d outs=%b", state, outs, illegal, s, e);
      end
    end
  endtask

  task automatic test_sw_wait();
    int s; bit m; logic [13:0] e;
    cur_op = OP_SW;
    model_instr(OP_SW, 0, 1);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
      #1;
      checks++;
      if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
        failures++;
        $display("[TB] FAIL sw_wait: state=%0d outs=%b illegal=%b, expected state=%0d outs=%b", state, outs, illegal, s, e);
      end
    end
  endtask

  task automatic test_beq_jal();
    int s; bit m; logic [13:0] e;
    for (int k = 0; k < 2; k++) begin
      cur_op = (k == 0) ? OP_BEQ : OP_JAL;
      model_instr(cur_op, 0, 0);
      while (st_q.size() > 0) begin
        s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
        @(negedge clk);
        mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
        #1;
        checks++;
        if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
          failures++;
          $display("[TB] FAIL beq_jal op=%b: state=%0d outs=%b, expected state=%0d outs=%b", cur_op, state, outs, s, e);
        end
      end
    end
  endtask

  task automatic test_fetch_wait();
    int s; bit m; logic [13:0] e;
    cur_op = OP_I;
    model_instr(OP_I, 3, 0);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
      #1;
      checks++;
      if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
        failures++;
        $display("[TB] FAIL fetch_wait: state=%0d outs=%b illegal=%b, expected state=%0d outs=%b", state, outs, illegal, s, e);
      end
    end
  endtask

  task automatic test_reset_in_memwrite();
    int s; bit m; logic [13:0] e;
    cur_op = OP_SW;
    push(0, 1'b1); push(1, 1'b1); push(2, 1'b1); push(5, 1'b0);
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
      #1;
      checks++;
      if (state !== 4'(s) || outs !== e) begin
        failures++;
        $display("[TB] FAIL reset_mw_setup: state=%0d outs=%b, expected state=%0d outs=%b", state, outs, s, e);
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || outs !== (exp_out(5, 1'b0) & ~STROBE_MASK)) begin
      failures++;
      $display("[TB] FAIL reset_mw_cycle: state=%0d outs=%b, expected state=5 outs=%b",
               state, outs, exp_out(5, 1'b0) & ~STROBE_MASK);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || outs !== exp_out(0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_mw_after: state=%0d outs=%b, expected state=0 outs=%b", state, outs, exp_out(0, 1'b0));
    end
  endtask

  task automatic test_illegal();
    int s; bit m; logic [13:0] e;
    cur_op = 7'b1111111;
    model_instr(cur_op, 0, 0);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) push(11, 1'($urandom_range(0, 1)));
`else
    cur_op = OP_R;
    model_instr(OP_R, 0, 0);
`endif
    while (st_q.size() > 0) begin
      s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
      @(negedge clk);
      mem_ready = m;
      op = (s == 1 && st_q.size() > 0 && st_q[0] == 11) ? 7'b1111111 :
           (s == 1 || s == 2) ? cur_op : 7'($urandom);
`ifndef MAIN_FSM_ILLEGAL_TRAP_EN
      if (s == 1 && st_q.size() > 0 && st_q[0] == 0) op = 7'b1111111;
`endif
      #1;
      checks++;
      if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
        failures++;
        $display("[TB] FAIL illegal: state=%0d outs=%b illegal=%b, expected state=%0d outs=%b illegal=%0d",
                 state, outs, illegal, s, e, s == 11);
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || outs !== exp_out(0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL illegal_clear: state=%0d illegal=%b outs=%b, expected state=0 illegal=0", state, illegal, outs);
    end
  endtask

  task automatic test_random();
    int s; bit m; logic [13:0] e;
    for (int n = 0; n < 40; n++) begin
      cur_op = legal_ops[$urandom_range(0, 5)];
`ifndef MAIN_FSM_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) begin
        cur_op = 7'($urandom);
        foreach (legal_ops[j]) if (cur_op == legal_ops[j]) cur_op = 7'b0001111;
      end
`endif
      model_instr(cur_op, $urandom_range(0, 2), $urandom_range(0, 2));
      while (st_q.size() > 0) begin
        s = st_q.pop_front(); m = mr_q.pop_front(); e = exp_out(s, m);
        @(negedge clk);
        mem_ready = m; op = (s == 1 || s == 2) ? cur_op : 7'($urandom);
        #1;
        checks++;
        if (state !== 4'(s) || illegal !== 1'(s == 11) || outs !== e) begin
          failures++;
          $display("[TB] FAIL random #%0d op=%b: state=%0d outs=%b, expected state=%0d outs=%b", n, cur_op, state, outs, s, e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; op = 7'd0; cur_op = 7'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq_jal();
    test_fetch_wait();
    test_reset_in_memwrite();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
